// File: rtl/deint_pkg.sv
// Shared sizing helpers and types for the block de-interleaver.
package deint_pkg;

   typedef logic bank_t;

   function automatic int deint_n(input int row, input int col);
      return row * col;
   endfunction

   // Width of an index into n entries; never narrower than one bit.
   function automatic int deint_aw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/deinterleaver_bank.sv
// One ping-pong bank: DATA_W x N storage, one write port, one asynchronous read port.
module deinterleaver_bank #(
   parameter int N      = 16384,
   parameter int AW     = 14,
   parameter int DATA_W = 1
) (
   input  logic              clk,
   input  logic              i_wr_en,
   input  logic [AW-1:0]     i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [AW-1:0]     i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [DATA_W-1:0] r_mem [N];

   // Contents are deliberately not reset; the full flags guard stale data.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/deinterleaver_sub.sv
// Block de-interleaver: column-major AXI-Stream in, row-major out, two ping-pong banks.
// Optional input framing check and writer resync: define DEINT_TLAST_CHECK_EN.
module deinterleaver_sub
   import deint_pkg::*;
#(
   parameter int ROW    = 512,
   parameter int COL    = 32,
   parameter int DATA_W = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   input  logic              s_axis_tlast,
   output logic              s_axis_tready,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   output logic              m_axis_tlast,
   input  logic              m_axis_tready,
   output logic              tlast_err
);

   localparam int N  = deint_n(ROW, COL);
   localparam int AW = deint_aw(N);
   localparam int RW = deint_aw(ROW);
   localparam int CW = deint_aw(COL);

   localparam logic [RW-1:0] ROW_LAST = RW'(ROW - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);
   localparam logic [AW-1:0] N_LAST   = AW'(N - 1);
   localparam logic [AW-1:0] COL_STEP = AW'(COL);

   logic              r_in_en;
   bank_t             r_wr_bank;
   bank_t             r_rd_bank;
   logic [1:0]        r_full;
   logic [RW-1:0]     r_row;
   logic [CW-1:0]     r_col;
   logic [AW-1:0]     r_wr_addr;
   logic [AW-1:0]     r_rd_idx;
   logic [DATA_W-1:0] r_m_tdata;
   logic              r_m_tvalid;
   logic              r_m_tlast;
   logic              r_tlast_err;

   logic              w_accept;
   logic              w_wr_last;
   logic              w_resync;
   logic              w_err;
   logic              w_load;
   logic              w_release;
   logic [AW-1:0]     w_wr_addr_nxt;
   logic [1:0]        w_full_set;
   logic [1:0]        w_full_clr;
   logic [DATA_W-1:0] w_bank_rd [2];
   logic [DATA_W-1:0] w_rd_data;

   assign s_axis_tready = r_in_en && !r_full[r_wr_bank];
   assign w_accept      = s_axis_tvalid && s_axis_tready;
   assign w_wr_last     = (r_row == ROW_LAST) && (r_col == COL_LAST);
   assign w_load        = (!r_m_tvalid || m_axis_tready) && r_full[r_rd_bank];
   assign w_release     = w_load && (r_rd_idx == N_LAST);
   assign w_rd_data     = w_bank_rd[r_rd_bank];

`ifdef DEINT_TLAST_CHECK_EN
   // Early tlast restarts the block in the same bank; a missing one only flags.
   assign w_resync = w_accept && s_axis_tlast && !w_wr_last;
   assign w_err    = w_accept && (s_axis_tlast != w_wr_last);
`else
   logic w_unused_tlast;
   assign w_unused_tlast = s_axis_tlast;
   assign w_resync       = 1'b0;
   assign w_err          = 1'b0;
`endif

   // Next write address: step by COL down a column, restart at the next column top.
   always_comb begin
      w_wr_addr_nxt = r_wr_addr + COL_STEP;
      if (w_wr_last || w_resync) begin
         w_wr_addr_nxt = '0;
      end else if (r_row == ROW_LAST) begin
         w_wr_addr_nxt = AW'(r_col) + AW'(1);
      end else begin
         w_wr_addr_nxt = r_wr_addr + COL_STEP;
      end
   end

   // Bank occupancy: writer and reader always touch different banks.
   always_comb begin
      w_full_set = 2'b00;
      w_full_clr = 2'b00;
      if (w_accept && w_wr_last) begin
         w_full_set[r_wr_bank] = 1'b1;
      end else begin
         w_full_set = 2'b00;
      end
      if (w_release) begin
         w_full_clr[r_rd_bank] = 1'b1;
      end else begin
         w_full_clr = 2'b00;
      end
   end

   // Writer state: enable, column-major counters, address and bank select.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_en   <= 1'b0;
         r_wr_bank <= 1'b0;
         r_row     <= '0;
         r_col     <= '0;
         r_wr_addr <= '0;
         r_full    <= 2'b00;
      end else begin
         r_in_en <= 1'b1;
         r_full  <= (r_full | w_full_set) & ~w_full_clr;
         if (w_resync) begin
            r_row     <= '0;
            r_col     <= '0;
            r_wr_addr <= '0;
         end else if (w_accept) begin
            r_wr_addr <= w_wr_addr_nxt;
            if (r_row == ROW_LAST) begin
               r_row <= '0;
               r_col <= (r_col == COL_LAST) ? '0 : r_col + CW'(1);
            end else begin
               r_row <= r_row + RW'(1);
            end
            if (w_wr_last) begin
               r_wr_bank <= ~r_wr_bank;
            end
         end
      end
   end

   // Reader and output stage: load, idle or hold under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_bank  <= 1'b0;
         r_rd_idx   <= '0;
         r_m_tdata  <= '0;
         r_m_tvalid <= 1'b0;
         r_m_tlast  <= 1'b0;
      end else if (w_load) begin
         r_m_tdata  <= w_rd_data;
         r_m_tvalid <= 1'b1;
         r_m_tlast  <= (r_rd_idx == N_LAST);
         if (w_release) begin
            r_rd_idx  <= '0;
            r_rd_bank <= ~r_rd_bank;
         end else begin
            r_rd_idx <= r_rd_idx + AW'(1);
         end
      end else if (m_axis_tready) begin
         r_m_tvalid <= 1'b0;
         r_m_tlast  <= 1'b0;
      end
   end

   // Framing error pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tlast_err <= 1'b0;
      end else begin
         r_tlast_err <= w_err;
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_bank
      deinterleaver_bank #(
         .N      (N),
         .AW     (AW),
         .DATA_W (DATA_W)
      ) u_bank (
         .clk       (clk),
         .i_wr_en   (w_accept && (r_wr_bank == bank_t'(g))),
         .i_wr_addr (r_wr_addr),
         .i_wr_data (s_axis_tdata),
         .i_rd_addr (r_rd_idx),
         .o_rd_data (w_bank_rd[g])
      );
   end

   assign m_axis_tdata  = r_m_tdata;
   assign m_axis_tvalid = r_m_tvalid;
   assign m_axis_tlast  = r_m_tlast;
   assign tlast_err     = r_tlast_err;

endmodule

// File: tb/tb_deinterleaver_sub.sv
// Scoreboard bench for deinterleaver_sub with ROW=4, COL=3, DATA_W=4.
module tb_deinterleaver_sub;

   localparam int ROW = 4;
   localparam int COL = 3;
   localparam int N   = ROW * COL;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] s_tdata;
   logic       s_tvalid;
   logic       s_tlast;
   logic       s_tready;
   logic [3:0] m_tdata;
   logic       m_tvalid;
   logic       m_tlast;
   logic       m_tready = 1'b0;
   logic       err;

   deinterleaver_sub #(.ROW(ROW), .COL(COL), .DATA_W(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tlast  (s_tlast),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tlast  (m_tlast),
      .m_axis_tready (m_tready),
      .tlast_err     (err)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   logic [4:0] exp_q[$];
   int hs_count = 0, hs_first = 0, hs_last = 0, tlast_count = 0;
   int err_pulses = 0, stalls = 0, last_acc_cyc = 0, acc_count = 0;
   int tready_mode = 1;
   logic       stalled_prev = 1'b0;
   logic [4:0] stall_beat = 5'd0;

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Downstream ready: 0 = stalled, 1 = always ready, 2 = random.
   initial forever begin
      @(posedge clk);
      #1;
      case (tready_mode)
         0:       m_tready = 1'b0;
         1:       m_tready = 1'b1;
         default: m_tready = 1'($urandom_range(0, 1));
      endcase
   end

   // Monitor: pops the scoreboard on each handshake and checks stall stability.
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         stalled_prev = 1'b0;
      end else begin
         if (stalled_prev) begin
            check("stall_hold", int'({m_tvalid, m_tlast, m_tdata}), int'({1'b1, stall_beat}));
         end
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", int'({m_tlast, m_tdata}), -1);
            end else begin
               check("out_beat", int'({m_tlast, m_tdata}), int'(exp_q.pop_front()));
            end
            if (hs_count == 0) hs_first = cyc;
            hs_last = cyc;
            hs_count++;
            if (m_tlast) tlast_count++;
         end
         stalled_prev = m_tvalid && !m_tready;
         stall_beat   = {m_tlast, m_tdata};
         if (err) err_pulses++;
      end
   end

   task automatic send_beat(input logic [3:0] d, input logic l, input bit rnd);
      int k;
      if (rnd && ($urandom_range(0, 1) == 1)) begin
         s_tvalid = 1'b0;
         @(posedge clk);
         #1;
      end
      s_tdata  = d;
      s_tlast  = l;
      s_tvalid = 1'b1;
      k = 0;
      forever begin
         @(negedge clk);
         if (s_tready) begin
            last_acc_cyc = cyc;
            acc_count++;
            @(posedge clk);
            #1;
            break;
         end
         stalls++;
         k++;
         if (k >= 2000) begin
            check("input_timeout", k, 0);
            @(posedge clk);
            #1;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_block(input int blk, input bit rnd);
      logic [3:0] v[N];
      for (int k = 0; k < N; k++) v[k] = 4'((k + blk * 3) % 16);
      for (int j = 0; j < N; j++) send_beat(v[(j % ROW) * COL + j / ROW], (j == N - 1), rnd);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      for (int k = 0; k < N; k++) exp_q.push_back({(k == N - 1), v[k]});
   endtask

   task automatic wait_drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 4000) begin
         @(posedge clk);
         k++;
      end
      repeat (3) @(posedge clk);
      #1;
      check("drain_left", exp_q.size(), 0);
   endtask

   task automatic clear_stats();
      hs_count = 0;
      tlast_count = 0;
      stalls = 0;
      acc_count = 0;
   endtask

   initial begin
      logic [3:0] in_vec[N];
      in_vec = '{4'd0, 4'd3, 4'd6, 4'd9, 4'd1, 4'd4, 4'd7, 4'd10, 4'd2, 4'd5, 4'd8, 4'd11};
      s_tvalid = 1'b0;
      s_tdata  = 4'd0;
      s_tlast  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_s_tready", int'(s_tready), 0);
      check("rst_m_tvalid", int'(m_tvalid), 0);
      check("rst_m_tdata", int'(m_tdata), 0);
      check("rst_m_tlast", int'(m_tlast), 0);
      check("rst_tlast_err", int'(err), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single block, hand-written column-major input.
      clear_stats();
      for (int j = 0; j < N; j++) send_beat(in_vec[j], (j == N - 1), 1'b0);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      for (int k = 0; k < N; k++) exp_q.push_back({(k == N - 1), 4'(k)});
      wait_drain();
      check("single_latency", hs_first - last_acc_cyc, 2);
      check("single_count", hs_count, N);
      check("single_tlasts", tlast_count, 1);

      // Back-to-back blocks at full rate.
      clear_stats();
      for (int b = 1; b <= 4; b++) send_block(b, 1'b0);
      wait_drain();
      check("b2b_count", hs_count, 4 * N);
      check("b2b_span", hs_last - hs_first, 4 * N - 1);
      check("b2b_tlasts", tlast_count, 4);
      check("b2b_in_stalls", stalls, 0);

      // Backpressure: both banks fill, then release.
      tready_mode = 0;
      @(posedge clk);
      #1;
      clear_stats();
      send_block(5, 1'b0);
      send_block(6, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("bp_tready_low", int'(s_tready), 0);
      check("bp_accepted", acc_count, 2 * N);
      @(posedge clk);
      #1;
      fork
         send_block(7, 1'b0);
         begin
            repeat (8) @(posedge clk);
            tready_mode = 1;
         end
      join
      wait_drain();
      check("bp_count", hs_count, 3 * N);
      check("bp_tlasts", tlast_count, 3);

      // Random valid/ready over 20 blocks.
      tready_mode = 2;
      clear_stats();
      for (int b = 0; b < 20; b++) send_block(10 + b, 1'b1);
      tready_mode = 1;
      wait_drain();
      check("rnd_count", hs_count, 20 * N);
      check("rnd_tlasts", tlast_count, 20);

      // Reset in the middle of a block.
      send_block(40, 1'b0);
      wait_drain();
      for (int j = 0; j < 7; j++) send_beat(4'(j + 9), 1'b0, 1'b0);
      s_tvalid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_s_tready", int'(s_tready), 0);
      check("mid_rst_m_tvalid", int'(m_tvalid), 0);
      check("mid_rst_m_tdata", int'(m_tdata), 0);
      check("mid_rst_m_tlast", int'(m_tlast), 0);
      check("mid_rst_tlast_err", int'(err), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      clear_stats();
      send_block(42, 1'b0);
      wait_drain();
      check("post_rst_count", hs_count, N);

`ifdef DEINT_TLAST_CHECK_EN
      // Early tlast on the fifth beat resynchronises the writer.
      begin
         int errs_before;
         errs_before = err_pulses;
         for (int j = 0; j < 5; j++) send_beat(4'(j), (j == 4), 1'b0);
         s_tvalid = 1'b0;
         s_tlast  = 1'b0;
         repeat (3) @(posedge clk);
         #1;
         check("early_tlast_err", err_pulses - errs_before, 1);
         clear_stats();
         send_block(50, 1'b0);
         wait_drain();
         check("resync_count", hs_count, N);
         check("total_tlast_err", err_pulses, 1);
      end
`else
      check("total_tlast_err", err_pulses, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
